// File: rtl/cluster_event_async_rx.sv
// cluster_event_async_rx
// Cluster-side read end of the SoC->cluster asynchronous event FIFO.
// The Gray write pointer is synchronised into clk_i, event words are read
// straight out of the writer-held slot array into an output register, and
// the Gray read pointer is handed back to the writer.
//
// Ports:
//   clk_i / rst_i                 cluster clock, async active-high reset
//   async_cluster_events_wptr_i   Gray write pointer (asynchronous to clk_i)
//   async_cluster_events_data_i   slot array, bit b of slot s at [b][s]
//   async_cluster_events_rptr_o   registered Gray read pointer
//   evt_valid_o/evt_data_o/evt_ready_i  event handshake to the event unit
//   fill_o                        registered pending count (excl. output reg)
//   proto_err_o                   sticky: pointer distance exceeded DEPTH
module cluster_event_async_rx #(
    parameter int LOG_DEPTH   = 3,
    parameter int EVNT_WIDTH  = 8,
    parameter int SYNC_STAGES = 2   // 2 or 3
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic [LOG_DEPTH:0]                        async_cluster_events_wptr_i,
    input  logic [EVNT_WIDTH-1:0][2**LOG_DEPTH-1:0]   async_cluster_events_data_i,
    output logic [LOG_DEPTH:0]                        async_cluster_events_rptr_o,
    output logic                                      evt_valid_o,
    output logic [EVNT_WIDTH-1:0]                     evt_data_o,
    input  logic                                      evt_ready_i,
    output logic [LOG_DEPTH:0]                        fill_o,
    output logic                                      proto_err_o
);

    localparam int PW    = LOG_DEPTH + 1;
    localparam int DEPTH = 2 ** LOG_DEPTH;

    typedef enum logic [1:0] {
        IDLE,    // nothing presented
        HOLD,    // word presented, FIFO behind it empty
        STREAM   // word presented, more queued behind it
    } state_t;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
    logic [PW-1:0]                  wptr_s, wptr_b;
    logic [PW-1:0]                  rptr_b, rptr_inc, diff;
    logic [EVNT_WIDTH-1:0]          slot_word;
    logic                           empty, load, valid_d;
    state_t                         state;

    // Plain flop chain on the Gray pointer; nothing combinational ahead of
    // stage 0 so only one bit can be in flight per writer increment.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], async_cluster_events_wptr_i};
    end

    assign wptr_s   = sync_q[SYNC_STAGES-1];
    assign wptr_b   = gray2bin(wptr_s);
    assign rptr_inc = rptr_b + 1'b1;
    assign diff     = wptr_b - rptr_b;
    // The registered Gray read pointer always equals gray(rptr_b), so it
    // doubles as the comparison operand for empty.
    assign empty    = (wptr_s == async_cluster_events_rptr_o);

    always_comb begin
        slot_word = '0;
        for (int b = 0; b < EVNT_WIDTH; b++)
            slot_word[b] = async_cluster_events_data_i[b][rptr_b[LOG_DEPTH-1:0]];
    end

    // Valid=0 with entries pending is a one-cycle transient handled as IDLE
    // (it loads immediately).
    always_comb begin
        if (!evt_valid_o) state = IDLE;
        else if (empty)   state = HOLD;
        else              state = STREAM;
    end

    always_comb begin
        load    = 1'b0;
        valid_d = evt_valid_o;
        case (state)
            IDLE:    load = !empty;
            HOLD:    if (evt_ready_i) valid_d = 1'b0;
            STREAM:  load = evt_ready_i;
            default: load = 1'b0;
        endcase
        if (load) valid_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rptr_b                      <= '0;
            async_cluster_events_rptr_o <= '0;
            evt_valid_o                 <= 1'b0;
            evt_data_o                  <= '0;
            fill_o                      <= '0;
            proto_err_o                 <= 1'b0;
        end else begin
            evt_valid_o <= valid_d;
            if (load) begin
                evt_data_o                  <= slot_word;
                rptr_b                      <= rptr_inc;
                async_cluster_events_rptr_o <= rptr_inc ^ (rptr_inc >> 1);
            end
            fill_o <= diff;
            // Only flagged; the reader keeps draining regardless.
            if (diff > PW'(DEPTH)) proto_err_o <= 1'b1;
        end
    end

endmodule
